// File: rtl/ps2_pkg.sv
// Shared encodings for the PS/2 frame receiver: FSM states, error causes
// and frame geometry.
package ps2_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_DATA   = 2'b01,
      ST_PARITY = 2'b10,
      ST_STOP   = 2'b11
   } ps2_state_e;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_PARITY  = 2'b01;
   localparam logic [1:0] ERR_FRAME   = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   // start + 8 data + parity + stop
   localparam int FRAME_BITS = 11;
   localparam int DATA_BITS  = FRAME_BITS - 3;

endpackage

// File: rtl/ps2_input_filter.sv
// Brings raw ps2Clk/ps2Data into the clk domain. ps2Clk is deglitched: the
// filtered level only follows the synchronised input after it has disagreed
// for FILTER_LEN consecutive cycles. A registered one-cycle strobe marks each
// filtered falling edge; ps2Data only gets a plain 2-FF synchroniser.
module ps2_input_filter #(
   parameter int FILTER_LEN = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_ps2_clk,
   input  logic i_ps2_data,
   output logic o_sync_data,
   output logic o_fall_stb
);

   localparam int CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

   logic             r_clk_s1;
   logic             r_clk_s2;
   logic             r_dat_s1;
   logic             r_dat_s2;
   logic             r_filt;
   logic             r_filt_q;
   logic [CNT_W-1:0] r_cnt;
   logic             r_fall;

   // Two-stage synchronisers; idle-high bus, so reset to 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
      end else begin
         r_clk_s1 <= i_ps2_clk;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= i_ps2_data;
         r_dat_s2 <= r_dat_s1;
      end
   end

   // Deglitch: count consecutive disagreeing samples, any agreement restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_filt <= 1'b1;
         r_cnt  <= '0;
      end else if (r_clk_s2 != r_filt) begin
         if (r_cnt == CNT_LAST) begin
            r_filt <= r_clk_s2;
            r_cnt  <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end else begin
         r_cnt <= '0;
      end
   end

   // Registered edge detect on the filtered clock; adds one fixed cycle of latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_filt_q <= 1'b1;
         r_fall   <= 1'b0;
      end else begin
         r_filt_q <= r_filt;
         r_fall   <= r_filt_q & ~r_filt;
      end
   end

   assign o_sync_data = r_dat_s2;
   assign o_fall_stb  = r_fall;

endmodule

// File: rtl/ps2_frame_receiver.sv
// PS/2 keyboard byte receiver running entirely on clk. Deframes one 11-bit
// frame per keystroke byte and reports either a good byte (rxValid) or a
// discarded frame with its cause (rxErr/errCode).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for a start bit (data=0 on a filtered falling edge)
// ST_DATA   | shifting in 8 data bits, LSB first, accumulating parity
// ST_PARITY | folding the parity bit into the accumulator
// ST_STOP   | checking stop bit and odd parity, emitting byte or error
module ps2_frame_receiver
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 200000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2Clk,
   input  logic       ps2Data,
   output logic [7:0] rxByte,
   output logic       rxValid,
   output logic       rxErr,
   output logic [1:0] errCode,
   output logic       busy
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
   localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

   logic             w_data;
   logic             w_fall;

   ps2_state_e       r_state;
   logic [2:0]       r_bit_cnt;
   logic [7:0]       r_shreg;
   logic             r_par;
   logic [TMO_W-1:0] r_tmo;
   logic [7:0]       r_byte;
   logic             r_valid;
   logic             r_err;
   logic [1:0]       r_err_code;

   ps2_input_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_filter (
      .clk         (clk),
      .rst         (rst),
      .i_ps2_clk   (ps2Clk),
      .i_ps2_data  (ps2Data),
      .o_sync_data (w_data),
      .o_fall_stb  (w_fall)
   );

   // Frame FSM with registered strobes; a falling edge always beats timeout expiry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_bit_cnt  <= '0;
         r_shreg    <= '0;
         r_par      <= 1'b0;
         r_tmo      <= '0;
         r_byte     <= '0;
         r_valid    <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= ERR_NONE;
      end else begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         if (w_fall) begin
            r_tmo <= '0;
            case (r_state)
               ST_IDLE: begin
                  // data=1 here is a spurious edge and is silently ignored
                  if (!w_data) begin
                     r_state   <= ST_DATA;
                     r_bit_cnt <= '0;
                     r_par     <= 1'b0;
                  end
               end
               ST_DATA: begin
                  r_shreg <= {w_data, r_shreg[7:1]};
                  r_par   <= r_par ^ w_data;
                  if (r_bit_cnt == LAST_BIT) begin
                     r_state <= ST_PARITY;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                  end
               end
               ST_PARITY: begin
                  r_par   <= r_par ^ w_data;
                  r_state <= ST_STOP;
               end
               ST_STOP: begin
                  // a missing stop bit is reported even when parity is also wrong
                  if (!w_data) begin
                     r_err      <= 1'b1;
                     r_err_code <= ERR_FRAME;
                  end else if (r_par) begin
                     r_byte  <= r_shreg;
                     r_valid <= 1'b1;
                  end else begin
                     r_err      <= 1'b1;
                     r_err_code <= ERR_PARITY;
                  end
                  r_state <= ST_IDLE;
               end
               default: r_state <= ST_IDLE;
            endcase
         end else if (r_state == ST_IDLE) begin
            r_tmo <= '0;
         end else if (r_tmo == TMO_LIMIT) begin
            r_tmo      <= '0;
            r_state    <= ST_IDLE;
            r_err      <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
         end else begin
            r_tmo <= r_tmo + TMO_W'(1);
         end
      end
   end

   assign rxByte  = r_byte;
   assign rxValid = r_valid;
   assign rxErr   = r_err;
   assign errCode = r_err_code;
   assign busy    = (r_state != ST_IDLE);

endmodule
